wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback (A) has priority over a FIFO of multi-cycle unit results (B).
// Optional anti-starvation stall of A is enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid_i,
  input  logic [ADDR_W-1:0]          a_addr_i,
  input  logic [DATA_W-1:0]          a_data_i,
  output logic                       a_stall_o,
  input  logic                       b_valid_i,
  output logic                       b_ready_o,
  input  logic [ADDR_W-1:0]          b_addr_i,
  input  logic [DATA_W-1:0]          b_data_i,
  output logic                       rf_we_o,
  output logic [ADDR_W-1:0]          rf_waddr_o,
  output logic [DATA_W-1:0]          rf_wdata_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t           mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic push, pop, grant_a, nonempty;
  wr_t  head;

  assign nonempty  = (count_q != '0);
  assign head      = mem_q[rptr_q];
  // Full blocks a push even if the head pops this cycle: no pass-through.
  assign b_ready_o = !reset && (count_q < CW'(DEPTH));
  assign push      = b_valid_i && b_ready_o;
  assign grant_a   = !reset && a_valid_i && !a_stall_o;
  assign pop       = !reset && !grant_a && nonempty;

`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(STARVE_MAX + 2);
  logic [WW-1:0] wait_q, wait_d;

  assign a_stall_o = !reset && (wait_q >= WW'(STARVE_MAX)) && nonempty;

  // Counts cycles the head sits un-granted; saturates at the threshold.
  always_comb begin
    wait_d = wait_q;
    if (!nonempty || pop)              wait_d = '0;
    else if (wait_q < WW'(STARVE_MAX)) wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign a_stall_o = 1'b0;
`endif

  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_a) begin
      rf_we_d    = (a_addr_i != '0);
      rf_waddr_d = a_addr_i;
      rf_wdata_d = a_data_i;
    end else if (pop) begin
      rf_we_d    = (head.addr != '0);
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{addr: b_addr_i, data: b_data_i};
  end

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign fifo_count_o = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=3).
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_stall, b_valid, b_ready, rf_we;
  logic [2:0]  a_addr, b_addr, rf_waddr;
  logic [15:0] a_data, b_data, rf_wdata;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_stall_o(a_stall),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .fifo_count_o(fifo_count)
  );

  typedef struct {
    logic        rst, av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [2:0]  ba;
    logic [15:0] bd;
    logic        e_rdy, e_stall, e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(logic rst, logic av, logic [2:0] aa, logic [15:0] ad,
                              logic bv, logic [2:0] ba, logic [15:0] bd,
                              logic e_rdy, logic e_we, logic [2:0] e_wa,
                              logic [15:0] e_wd, logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.e_rdy = e_rdy; v.e_stall = 1'b0; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [15:0] bd);
    reset = rst; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // Inputs change on negedge; comb outputs checked mid-low phase, registers #1 after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input logic we, input logic [2:0] wa,
                      input logic [15:0] wd, input logic [1:0] cnt);
    chk({tag, " rf_we"}, int'(rf_we), int'(we));
    chk({tag, " rf_waddr"}, int'(rf_waddr), int'(wa));
    chk({tag, " rf_wdata"}, int'(rf_wdata), int'(wd));
    chk({tag, " fifo_count"}, int'(fifo_count), int'(cnt));
  endtask

  initial begin
    //          rst av aa    ad       bv ba    bd        rdy we wa    wd       cnt
    tv[0]  = mk(1, 1, 3'd3, 16'h1111, 1, 3'd5, 16'h2222, 0, 0, 3'd0, 16'h0000, 2'd0);
    tv[1]  = mk(1, 1, 3'd3, 16'h1111, 1, 3'd5, 16'h2222, 0, 0, 3'd0, 16'h0000, 2'd0);
    tv[2]  = mk(0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 1, 3'd3, 16'h1234, 2'd0);
    tv[3]  = mk(0, 0, 3'd0, 16'h0000, 1, 3'd5, 16'hBEEF, 1, 0, 3'd3, 16'h1234, 2'd1);
    tv[4]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd5, 16'hBEEF, 2'd0);
    tv[5]  = mk(0, 1, 3'd1, 16'h0A01, 1, 3'd6, 16'h0001, 1, 1, 3'd1, 16'h0A01, 2'd1);
    tv[6]  = mk(0, 1, 3'd2, 16'h0A02, 1, 3'd6, 16'h0002, 1, 1, 3'd2, 16'h0A02, 2'd2);
    tv[7]  = mk(0, 1, 3'd4, 16'h0A04, 1, 3'd6, 16'h0003, 0, 1, 3'd4, 16'h0A04, 2'd2);
    tv[8]  = mk(0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0003, 0, 1, 3'd6, 16'h0001, 2'd1);
    tv[9]  = mk(0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0003, 1, 1, 3'd6, 16'h0002, 2'd1);
    tv[10] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd6, 16'h0003, 2'd0);
    tv[11] = mk(0, 1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'hFFFF, 2'd0);
    tv[12] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd0, 16'h5555, 1, 0, 3'd0, 16'hFFFF, 2'd1);
    tv[13] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'h5555, 2'd0);
    tv[14] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'h5555, 2'd0);
    tv[15] = mk(0, 1, 3'd7, 16'h7777, 1, 3'd2, 16'h2020, 1, 1, 3'd7, 16'h7777, 2'd1);
    tv[16] = mk(1, 1, 3'd7, 16'h7777, 1, 3'd2, 16'h2020, 0, 0, 3'd0, 16'h0000, 2'd0);
    tv[17] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'h0000, 2'd0);

    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].av, tv[i].aa, tv[i].ad, tv[i].bv, tv[i].ba, tv[i].bd);
      #1;
      chk($sformatf("v%0d b_ready", i), int'(b_ready), int'(tv[i].e_rdy));
      chk($sformatf("v%0d a_stall", i), int'(a_stall), int'(tv[i].e_stall));
      step();
      regs($sformatf("v%0d", i), tv[i].e_we, tv[i].e_wa, tv[i].e_wd, tv[i].e_cnt);
    end

`ifdef WB_STARVE_GUARD_EN
    // Cycle N: one B entry accepted while A is held; head waits 3 cycles, then A stalls once.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      drive(0, 1, 3'd3, 16'hAAAA, (c == 0), 3'd4, 16'hB0B0);
      #1;
      chk($sformatf("starve N+%0d a_stall", c), int'(a_stall), (c == 4) ? 1 : 0);
      step();
      if (c == 4)      regs("starve N+5", 1, 3'd4, 16'hB0B0, 2'd0);
      else if (c == 5) regs("starve N+6", 1, 3'd3, 16'hAAAA, 2'd0);
      else if (c < 4)  regs($sformatf("starve N+%0d", c + 1), 1, 3'd3, 16'hAAAA, 2'd1);
    end
`else
    // Without the guard, a held A starves the FIFO head indefinitely.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      drive(0, 1, 3'd3, 16'hAAAA, (c == 0), 3'd4, 16'hB0B0);
      #1;
      chk($sformatf("nostarve N+%0d a_stall", c), int'(a_stall), 0);
      step();
      regs($sformatf("nostarve N+%0d", c + 1), 1, 3'd3, 16'hAAAA, 2'd1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    regs("nostarve drain", 1, 3'd4, 16'hB0B0, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
